// File: rtl/alu_32_2x2.sv
// alu_32_2x2: 32-bit, two-operand, two-result ALU for the CPU32 datapath.
// The datapath is purely combinational and feeds a single bank of output
// registers, so every operation has exactly one clock of latency and a new
// operation can be accepted on every cycle.
module alu_32_2x2 (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [7:0]  op,
  output logic [31:0] ql,
  output logic [31:0] qh,
  output logic [3:0]  fout
);

  typedef enum logic [7:0] {
    OP_PASS = 8'd0,
    OP_ADD  = 8'd1,
    OP_SUB  = 8'd2,
    OP_NEG  = 8'd3,
    OP_MUL  = 8'd4,
    OP_SHR  = 8'd5,
    OP_SHL  = 8'd6,
    OP_SAR  = 8'd7,
    OP_SAL  = 8'd8,
    OP_ROR  = 8'd9,
    OP_ROL  = 8'd10,
    OP_NOT  = 8'd11,
    OP_AND  = 8'd12,
    OP_OR   = 8'd13,
    OP_XOR  = 8'd14,
    OP_NAND = 8'd15,
    OP_NOR  = 8'd16,
    OP_XNOR = 8'd17
  } op_e;

  // Shift/rotate amount; the upper bits of b are deliberately ignored.
  logic [4:0]  sh;

  // Widened intermediates: the extra bit of each shift captures the last bit
  // shifted out, so carry needs no separate variable-index mux.
  logic [32:0] sum33;
  logic [32:0] dif33;
  logic [63:0] prod;
  logic [32:0] shl33;
  logic [32:0] shr33;
  logic [32:0] sar33;
  logic [31:0] sal32;
  logic [30:0] sal_mask;
  logic [31:0] rot_r;
  logic [31:0] rot_l;

  logic [31:0] res_lo;
  logic [31:0] res_hi;
  logic        flag_v;
  logic        flag_c;
  logic        flag_n;
  logic        flag_z;

  assign sh       = b[4:0];
  assign sum33    = {1'b0, a} + {1'b0, b};
  assign dif33    = {1'b0, a} - {1'b0, b};
  assign prod     = {32'd0, a} * {32'd0, b};
  assign shl33    = {1'b0, a} << sh;
  assign shr33    = {a, 1'b0} >> sh;
  assign sar33    = $signed({a, 1'b0}) >>> sh;
  // SAL keeps a[31] fixed and shifts only the low 31 bits; bit 31 of this
  // shifted value is the last bit pushed out of the 31-bit field.
  assign sal32    = {1'b0, a[30:0]} << sh;
  // Marks the bits of a[30:0] that SAL discards (the top sh bits).
  assign sal_mask = ~(31'h7fff_ffff >> sh);
  // For sh == 0 the complementary shift is by 32 and contributes nothing.
  assign rot_r    = (a >> sh) | (a << (6'd32 - {1'b0, sh}));
  assign rot_l    = (a << sh) | (a >> (6'd32 - {1'b0, sh}));

  // Select the result words and per-operation carry/overflow, then derive N/Z.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // through the case leaves a value unassigned, which would infer a latch.
    res_lo = 32'd0;
    res_hi = 32'd0;
    flag_v = 1'b0;
    flag_c = 1'b0;
    flag_n = 1'b0;
    flag_z = 1'b0;

    case (op)
      OP_PASS: begin
        res_lo = a;
        res_hi = b;
      end
      OP_ADD: begin
        res_lo = sum33[31:0];
        flag_c = sum33[32];
        flag_v = (a[31] == b[31]) && (sum33[31] != a[31]);
      end
      OP_SUB: begin
        res_lo = dif33[31:0];
        flag_c = dif33[32];
        flag_v = (a[31] != b[31]) && (dif33[31] != a[31]);
      end
      OP_NEG: begin
        res_lo = 32'd0 - a;
        flag_c = (a != 32'd0);
        flag_v = (a == 32'h8000_0000);
      end
      OP_MUL: begin
        res_lo = prod[31:0];
        res_hi = prod[63:32];
        flag_c = (prod[63:32] != 32'd0);
      end
      OP_SHR: begin
        res_lo = shr33[32:1];
        flag_c = shr33[0];
      end
      OP_SHL: begin
        res_lo = shl33[31:0];
        flag_c = shl33[32];
      end
      OP_SAR: begin
        res_lo = sar33[32:1];
        flag_c = sar33[0];
      end
      OP_SAL: begin
        res_lo = {a[31], sal32[30:0]};
        flag_c = sal32[31];
        flag_v = ((a[30:0] ^ {31{a[31]}}) & sal_mask) != 31'd0;
      end
      OP_ROR:  res_lo = rot_r;
      OP_ROL:  res_lo = rot_l;
      OP_NOT:  res_lo = ~a;
      OP_AND:  res_lo = a & b;
      OP_OR:   res_lo = a | b;
      OP_XOR:  res_lo = a ^ b;
      OP_NAND: res_lo = ~(a & b);
      OP_NOR:  res_lo = ~(a | b);
      OP_XNOR: res_lo = ~(a ^ b);
      default: begin
        // Reserved opcodes: results and every flag stay at zero.
        res_lo = 32'd0;
      end
    endcase

    // N and Z follow the result; PASS and MUL judge zero over both words.
    if (op <= OP_XNOR) begin
      flag_n = (op == OP_MUL) ? res_hi[31] : res_lo[31];
      if (op == OP_PASS || op == OP_MUL)
        flag_z = (res_lo == 32'd0) && (res_hi == 32'd0);
      else
        flag_z = (res_lo == 32'd0);
    end
  end

  // Output register stage with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      ql   <= 32'd0;
      qh   <= 32'd0;
      fout <= 4'd0;
    end else begin
      ql   <= res_lo;
      qh   <= res_hi;
      fout <= {flag_v, flag_c, flag_n, flag_z};
    end
  end

endmodule

// File: tb/tb_alu_32_2x2.sv
// Directed self-checking bench for alu_32_2x2. Inputs are driven 1 ns after
// a rising edge and outputs are sampled 1 ns after the following edge.
module tb_alu_32_2x2;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [7:0]  op;
  logic [31:0] ql;
  logic [31:0] qh;
  logic [3:0]  fout;

  int checks;
  int errors;

  alu_32_2x2 dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .op   (op),
    .ql   (ql),
    .qh   (qh),
    .fout (fout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one operation and advance past the edge that registers it.
  task automatic run(input logic [7:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o;
    a  = x;
    b  = y;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] lo, input logic [31:0] hi,
                            input logic [3:0] f);
    check({tag, ".ql"},   {32'd0, ql},   {32'd0, lo});
    check({tag, ".qh"},   {32'd0, qh},   {32'd0, hi});
    check({tag, ".fout"}, {60'd0, fout}, {60'd0, f});
  endtask

  // Shift/rotate table: ops 5..10 with a=80000001, amount 1.
  logic [7:0]  sh_op  [6];
  logic [31:0] sh_res [6];
  logic [3:0]  sh_flg [6];
  // Logic table with a=F0F0F0F0, b=FF00FF00.
  logic [7:0]  lg_op  [7];
  logic [31:0] lg_res [7];
  logic [3:0]  lg_flg [7];

  logic [31:0] ra;
  logic [31:0] rb;
  logic [31:0] rc;
  logic [31:0] rd;
  logic [63:0] mexp;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    op  = 8'd0;
    a   = 32'd0;
    b   = 32'd0;

    sh_op  = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10};
    sh_res = '{32'h4000_0000, 32'h0000_0002, 32'hC000_0000,
               32'h8000_0002, 32'hC000_0000, 32'h0000_0003};
    sh_flg = '{4'b0100, 4'b0100, 4'b0110, 4'b1010, 4'b0010, 4'b0000};

    lg_op  = '{8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 8'd11};
    lg_res = '{32'hF000_F000, 32'hFFF0_FFF0, 32'h0FF0_0FF0, 32'h0FFF_0FFF,
               32'h000F_000F, 32'hF00F_F00F, 32'h0F0F_0F0F};
    lg_flg = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000};

    // Reset overrides an ADD in the same cycle.
    @(posedge clk);
    #1;
    run(8'd1, 32'd5, 32'd7);
    expect_out("reset", 32'd0, 32'd0, 4'b0000);
    rst = 1'b0;
    run(8'd1, 32'd5, 32'd7);
    expect_out("add_5_7", 32'd12, 32'd0, 4'b0000);

    // Arithmetic corner cases; fout = {V,C,N,Z}.
    run(8'd1, 32'hFFFF_FFFF, 32'd1);
    expect_out("add_carry", 32'd0, 32'd0, 4'b0101);
    run(8'd1, 32'h7FFF_FFFF, 32'd1);
    expect_out("add_ovf", 32'h8000_0000, 32'd0, 4'b1010);
    run(8'd2, 32'd3, 32'd5);
    expect_out("sub_borrow", 32'hFFFF_FFFE, 32'd0, 4'b0110);
    run(8'd3, 32'h8000_0000, 32'd0);
    expect_out("neg_min", 32'h8000_0000, 32'd0, 4'b1110);
    run(8'd3, 32'd0, 32'd9);
    expect_out("neg_zero", 32'd0, 32'd0, 4'b0001);

    // Full-width multiply and pass-through.
    run(8'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    expect_out("mul_max", 32'h0000_0001, 32'hFFFF_FFFE, 4'b0110);
    run(8'd4, 32'd0, 32'h1234_5678);
    expect_out("mul_zero", 32'd0, 32'd0, 4'b0001);
    run(8'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    expect_out("pass", 32'h1234_5678, 32'h9ABC_DEF0, 4'b0000);
    run(8'd0, 32'd0, 32'd1);
    expect_out("pass_b_only", 32'd0, 32'd1, 4'b0000);

    // Shifts/rotates by 1 (b[31:5] set to prove they are ignored), then by 0.
    for (int i = 0; i < 6; i++) begin
      run(sh_op[i], 32'h8000_0001, 32'h0000_0021);
      expect_out($sformatf("shift_op%0d_by1", sh_op[i]), sh_res[i], 32'd0, sh_flg[i]);
    end
    for (int i = 0; i < 6; i++) begin
      run(sh_op[i], 32'h8000_0001, 32'h0000_0020);
      expect_out($sformatf("shift_op%0d_by0", sh_op[i]), 32'h8000_0001, 32'd0, 4'b0010);
    end
    // SAL where all discarded bits match the sign: no overflow.
    run(8'd8, 32'hF000_0001, 32'd3);
    expect_out("sal_noovf", 32'h8000_0008, 32'd0, 4'b0110);

    // Bitwise logic.
    for (int i = 0; i < 7; i++) begin
      run(lg_op[i], 32'hF0F0_F0F0, 32'hFF00_FF00);
      expect_out($sformatf("logic_op%0d", lg_op[i]), lg_res[i], 32'd0, lg_flg[i]);
    end

    // Back-to-back ADD, MUL, reserved: each result one edge after issue.
    ra = $urandom;
    rb = $urandom;
    rc = $urandom;
    rd = $urandom;
    run(8'd1, ra, rb);
    check("pipe_add.ql", {32'd0, ql}, {32'd0, ra + rb});
    check("pipe_add.qh", {32'd0, qh}, 64'd0);
    run(8'd4, rc, rd);
    mexp = {32'd0, rc} * {32'd0, rd};
    check("pipe_mul", {qh, ql}, mexp);
    run(8'd18, rb, ra);
    expect_out("pipe_rsvd18", 32'd0, 32'd0, 4'b0000);
    run(8'd255, 32'd0, 32'd0);
    expect_out("rsvd255", 32'd0, 32'd0, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_32_2x2.md
Name: alu_32_2x2

Overview:
- 32-bit two-operand, two-result ALU (2 inputs a/b, 2 outputs ql/qh) for the CPU32 datapath.
- Performs pass-through, add/sub/negate, 32x32->64 unsigned multiply, shifts/rotates and bitwise logic, selected by an 8-bit opcode.
- Results and 4-bit status flags are registered: one clock of latency.

Parameters:
- none (width fixed at 32)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- a  input  32  operand A
- b  input  32  operand B; shift/rotate amount is b[4:0]
- op  input  8  operation select
- ql  output  32  low result word (registered)
- qh  output  32  high result word (registered)
- fout  output  4  flags {V,C,N,Z} = fout[3:0] (registered)

Behaviour:
- Reset: one clock, synchronous, active-high. At a rising edge with rst=1, ql=0, qh=0 and fout=0. Reset overrides any operation in that cycle; there is no other state.
- Latency: a, b and op are sampled at rising edge N; results appear at N+1. A new operation is accepted every cycle (fully pipelined, single stage). The datapath is combinational before the output registers.
- qh=0 for every op except 0 and 4. Operations:
  - 0 PASS: ql=a, qh=b
  - 1 ADD: ql=a+b mod 2^32
  - 2 SUB: ql=a-b mod 2^32
  - 3 NEG: ql=-a (two's complement)
  - 4 MUL: {qh,ql} = a*b, unsigned, full 64-bit
  - 5 SHR: ql = a >> b[4:0], logical, zero fill
  - 6 SHL: ql = a << b[4:0], zero fill
  - 7 SAR: ql = a >>> b[4:0], sign fill from a[31]
  - 8 SAL: ql[31]=a[31]; ql[30:0] = (a[30:0] << b[4:0])[30:0]
  - 9 ROR: rotate a right by b[4:0]
  - 10 ROL: rotate a left by b[4:0]
  - 11 NOT: ql = ~a
  - 12 AND, 13 OR, 14 XOR: bitwise a op b
  - 15 NAND, 16 NOR, 17 XNOR: bitwise a op b
  - 18..255: reserved; ql=0, qh=0, fout=0
- Shift amount: b[31:5] are ignored. An amount of 0 returns a unchanged, with SAL also unchanged.
- Flags, computed from the same-cycle result:
  - Z: result is zero. For op 4, Z is set when the 64-bit product is zero. For op 0, Z=(a==0 && b==0).
  - N: ql[31]; for op 4, qh[31].
  - C:
    - ADD: carry out of bit 31.
    - SUB: borrow, i.e. a<b unsigned.
    - NEG: a!=0.
    - MUL: qh!=0.
    - SHR/SAR/SHL/SAL: last bit shifted out, 0 when amount is 0.
    - All other ops: 0.
  - V:
    - ADD: signed overflow.
    - SUB: signed overflow.
    - NEG: a==0x80000000.
    - SAL: any discarded bit differs from a[31].
    - All other ops: 0.

Test Plan:
- Reset: rst=1 for one edge with op=1, a=5, b=7 -> ql=0, qh=0, fout=0. Deassert rst; the next edge gives ql=12, fout=0.
- Arithmetic:
  - ADD a=FFFFFFFF, b=1 -> ql=0, Z=1, C=1, V=0.
  - ADD a=7FFFFFFF, b=1 -> ql=80000000, N=1, V=1.
  - SUB a=3, b=5 -> ql=FFFFFFFE, C=1.
  - NEG a=80000000 -> ql=80000000, V=1.
- MUL and PASS:
  - MUL a=FFFFFFFF, b=FFFFFFFF -> qh=FFFFFFFE, ql=00000001, C=1.
  - PASS a=12345678, b=9ABCDEF0 -> ql=12345678, qh=9ABCDEF0.
- Shifts/rotates with a=80000001, b=00000021 (amount 1):
  - SHR -> 40000000
  - SHL -> 00000002
  - SAR -> C0000000
  - SAL -> 80000002
  - ROR -> C0000000
  - ROL -> 00000003
  - Amount 0 (b=20) returns 80000001 for all six.
- Logic with a=F0F0F0F0, b=FF00FF00:
  - AND F000F000, OR FFF0FFF0, XOR 0FF00FF0
  - NAND 0FFF0FFF, NOR 000F000F, XNOR F00FF00F
  - NOT 0F0F0F0F
  - qh=0 for all.
- Pipelining/reserved: issue ops 1, 4, 18 on consecutive cycles with random a/b -> each result appears exactly one edge later with no bubbles. The op 18 cycle gives ql=qh=0 and fout=0.
